// File: rtl/dbg_scan_pkg.sv
// Shared types and constants for the debug read-out scanner.
package dbg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    CAP  = 2'd3
  } state_t;

  // Width of the address tag placed in the top byte of the display word.
  localparam int TAG_W = 8;

  // All-ones blanks the seven-segment display; sliced down to DW at use.
  localparam logic [255:0] BLANK_WORD = '1;

endpackage

// File: rtl/dbg_scan_pacer.sv
// Scan pacing: free-running auto-scan tick and single-step rising-edge detect.
module dbg_scan_pacer #(
  parameter int TICK_DIV = 2**25
) (
  input  logic clk,
  input  logic rstn,
  input  logic auto_en,
  input  logic step_btn,
  output logic tick,
  output logic adv
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          step_q;

  // Tick counter runs only while auto-scan is enabled; step level is delayed for edge detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step_btn;
      if (!auto_en || cnt == CW'(TICK_DIV - 1)) cnt <= '0;
      else                                       cnt <= cnt + CW'(1);
    end
  end

  assign tick = auto_en && (cnt == CW'(TICK_DIV - 1));
  // A tick and a step edge in the same cycle collapse into one advance.
  assign adv  = tick | (step_btn & ~step_q);

endmodule

// File: rtl/dbg_view_scanner.sv
// Debug read-out scanner: walks DEPTH entries of the selected source and
// latches each one as a display word.
// Optional build macro DBG_SCAN_TAG_EN: top byte of the display word carries
// the entry address (requires AW <= 8).
module dbg_view_scanner
  import dbg_scan_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int AW       = 6,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 2**25,
  parameter int RD_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [$clog2(NCH)-1:0]   ch_sel,
  input  logic                     auto_en,
  input  logic                     step_btn,
  input  logic                     clr,
  output logic [NCH-1:0]           rd_req,
  output logic [AW-1:0]            rd_addr,
  input  logic [NCH*DW-1:0]        rd_data,
  output logic [DW-1:0]            disp_data,
  output logic                     disp_valid,
  output logic [AW-1:0]            cur_addr
);

  localparam int CHW = $clog2(NCH);

  state_t                  state;
  logic [1:0]              wcnt;
  logic [CHW-1:0]          ch_q;
  logic [AW-1:0]           nxt_addr;
  logic [AW-1:0]           addr_inc;
  logic [NCH-1:0][DW-1:0]  rd_arr;
  logic [DW-1:0]           sel_data;
  logic [DW-1:0]           cap_word;
  logic                    tick, adv, adv_ev, restart, take;

  dbg_scan_pacer #(.TICK_DIV(TICK_DIV)) u_pacer (
    .clk      (clk),
    .rstn     (rstn),
    .auto_en  (auto_en),
    .step_btn (step_btn),
    .tick     (tick),
    .adv      (adv)
  );

  // tick is already folded into adv; kept here so it stays probe-able at the top.
  assign adv_ev  = adv | tick;
  assign restart = clr | (ch_sel != ch_q);

  // The read result is taken on the edge that leaves the last latency cycle,
  // so CAP itself is the cycle in which the fresh word is already on display.
  assign take = (state == REQ  && RD_LAT == 0) ||
                (state == WAIT && wcnt == 2'(RD_LAT - 1));

  assign rd_arr   = rd_data;
  assign sel_data = rd_arr[ch_q];
  assign addr_inc = (rd_addr == AW'(DEPTH - 1)) ? '0 : rd_addr + AW'(1);

`ifdef DBG_SCAN_TAG_EN
  assign cap_word = {TAG_W'(rd_addr), sel_data[DW-TAG_W-1:0]};
`else
  assign cap_word = sel_data;
`endif

  // Registered copy of the channel select; any mismatch is a restart.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ch_q <= '0;
    else       ch_q <= ch_sel;
  end

  // Scan FSM with address counter and registered display outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wcnt       <= '0;
      rd_req     <= '0;
      rd_addr    <= '0;
      nxt_addr   <= '0;
      cur_addr   <= '0;
      disp_valid <= 1'b0;
      disp_data  <= BLANK_WORD[DW-1:0];
    end else if (restart) begin
      state      <= IDLE;
      rd_req     <= '0;
      nxt_addr   <= '0;
      cur_addr   <= '0;
      disp_valid <= 1'b0;
      disp_data  <= BLANK_WORD[DW-1:0];
    end else begin
      rd_req <= '0;
      if (take) begin
        disp_data  <= cap_word;
        cur_addr   <= rd_addr;
        disp_valid <= 1'b1;
        nxt_addr   <= addr_inc;
      end
      case (state)
        IDLE: if (adv_ev) begin
          state   <= REQ;
          rd_req  <= NCH'(1) << ch_q;
          rd_addr <= nxt_addr;
        end
        REQ: begin
          wcnt  <= '0;
          state <= (RD_LAT == 0) ? CAP : WAIT;
        end
        WAIT: begin
          if (take) state <= CAP;
          else      wcnt  <= wcnt + 2'd1;
        end
        CAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbg_view_scanner.md
# dbg_view_scanner

Parametrised debug read-out scanner for the tinyCPU board top. It walks the entries of one of NCH selectable debug sources (instruction ROM, register file, ALU taps, data memory, …) through a uniform synchronous read port. Each entry is presented as one display word for the seven-segment driver. Scanning is paced by an internal clk-enable tick or by single-step button edges; there are no derived clocks.

## Interface
- NCH, 4 — number of debug source channels (≥2)
- DW, 32 — display/data word width
- AW, 6 — entry address width
- DEPTH, 16 — entries scanned per channel, 1..2^AW; address wraps after DEPTH-1
- TICK_DIV, 2**25 — auto-scan period in clk cycles (≥2)
- RD_LAT, 1 — source read latency in cycles, 0..3
- Reset: rstn, asynchronous, active-low; clock: clk.
- clk  in  1  system clock
- rstn  in  1  async active-low reset
- ch_sel  in  $clog2(NCH)  selected source channel
- auto_en  in  1  1 = advance on internal tick
- step_btn  in  1  already-debounced, synchronous button level; each rising edge requests one advance
- clr  in  1  synchronous restart at entry 0
- rd_req  out  NCH  one-hot read strobe to the selected source
- rd_addr  out  AW  read address, shared by all channels
- rd_data  in  NCH*DW  channel k data on bits [k*DW +: DW]
- disp_data  out  DW  word for display
- disp_valid  out  1  disp_data holds a capture from the current channel
- cur_addr  out  AW  address of the entry in disp_data

## Operation
- Reset values: rd_req 0, rd_addr 0, disp_data all-ones (blank), disp_valid 0, cur_addr 0, FSM IDLE, tick counter 0, next address 0.
- Advance event = tick (auto_en=1) OR step rising edge (step_btn & ~step_q). A tick and an edge in the same cycle count as one advance.
- Events that arrive while the FSM is not in IDLE are dropped. There is no queueing.
- FSM states and transitions:
  - IDLE → REQ on an advance event.
  - REQ drives rd_req[ch_sel]=1 and rd_addr=next address for exactly one cycle. REQ → WAIT if RD_LAT>0, else → CAP.
  - WAIT counts RD_LAT-1 further cycles, then → CAP.
  - CAP samples rd_data slice ch_sel. It loads disp_data and cur_addr=rd_addr and sets disp_valid=1. It then sets next address = rd_addr+1, or 0 if rd_addr==DEPTH-1. CAP → IDLE.
- Tick counter: runs 0..TICK_DIV-1 while auto_en=1; tick pulses in the cycle the count equals TICK_DIV-1, and the counter wraps to 0. auto_en=0 holds the counter at 0.
- Channel change: ch_sel is registered. A mismatch with the registered copy acts as a restart.
- Restart (clr=1 or channel change) has priority over everything:
  - FSM returns to IDLE and any in-flight read is aborted with no capture.
  - next address, cur_addr and disp_valid go to 0; disp_data goes to all-ones; rd_req goes to 0.
  - An advance event in the same cycle as a restart is dropped.
- Async reset mid-scan returns every register to its reset value immediately.

## Timing
- An advance event seen in cycle c puts REQ in cycle c+1.
- Sampling happens at the end of cycle c+1+RD_LAT.
- disp_data, cur_addr and disp_valid are updated from cycle c+2+RD_LAT.
- Advance-to-display latency is therefore RD_LAT+2 cycles. The FSM is busy for RD_LAT+2 cycles.
- rd_req is never high for more than one consecutive cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DBG_SCAN_TAG_EN defined:
  - disp_data[DW-1:DW-8] = cur_addr zero-extended to 8 bits; disp_data[DW-9:0] = sampled data[DW-9:0].
  - Requires AW ≤ 8.
- DBG_SCAN_TAG_EN undefined: disp_data = the sampled data unmodified.

## Structure
- Package dbg_scan_pkg holds:
  - state enum (IDLE, REQ, WAIT, CAP)
  - BLANK_WORD (all-ones)
  - TAG_W = 8
- Sub-module dbg_scan_pacer holds the tick counter and step edge detector. Its output is a single adv pulse plus tick for observation.
- The FSM, address counter and output registers live in the top module.

## Test plan
- Reset release, all inputs 0 → outputs stay at reset values for 100 cycles; rd_req never pulses.
- TICK_DIV=4, RD_LAT=1, ch_sel=2, auto_en=1, channel 2 returns 0xA000_0000+addr → rd_req[2] pulses every 4 cycles. disp_data reads A000_0000, A000_0001, …, then A000_000F, then A000_0000 again (DEPTH=16 wrap). With the tag macro defined: 0000_0000, 0100_0001, … .
- auto_en=0, three step_btn rising edges spaced 10 cycles apart, plus step held high for 50 cycles → exactly 3 captures, at addresses 0, 1, 2. Each capture lands RD_LAT+2 cycles after its edge.
- Step edge 1 cycle after a REQ, with RD_LAT=3 → the edge is dropped; exactly one capture occurs.
- ch_sel changes 0→1 while in WAIT → no capture; disp_valid=0 and disp_data=FFFF_FFFF. The next advance reads channel 1 address 0.
- clr and tick in the same cycle mid-scan at address 9 → no REQ that cycle; the next tick reads address 0.
